// File: rtl/rapcla_issue_stage.sv
// Two-stage issue/retire wrapper around a combinational RAPCLA adder.
// Picks per-group approximation control per beat and counts retired results.
module rapcla_issue_stage #(
    parameter int SIZE      = 16,
    parameter int GROUPSIZE = 4,
    parameter int CNTW      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SIZE-1:0]            in_a,
    input  logic [SIZE-1:0]            in_b,
    input  logic                       in_cin,
    input  logic [1:0]                 cfg_mode,
    input  logic [SIZE/GROUPSIZE-1:0]  cfg_mask,
    input  logic [7:0]                 cfg_period,
    output logic [SIZE-1:0]            add_a,
    output logic [SIZE-1:0]            add_b,
    output logic                       add_cin,
    output logic [SIZE/GROUPSIZE-1:0]  add_rcon,
    input  logic [SIZE-1:0]            add_sum,
    input  logic                       add_cout,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SIZE-1:0]            out_sum,
    output logic                       out_cout,
    output logic                       out_approx,
    input  logic                       stat_clr,
    output logic [CNTW-1:0]            stat_ops,
    output logic [CNTW-1:0]            stat_approx
);
    localparam int GROUPS = SIZE / GROUPSIZE;

    localparam logic [1:0] MODE_EXACT  = 2'd0;
    localparam logic [1:0] MODE_APPROX = 2'd1;
    localparam logic [1:0] MODE_MASK   = 2'd2;
    localparam logic [1:0] MODE_PERIOD = 2'd3;

    logic [SIZE-1:0]   r_a;
    logic [SIZE-1:0]   r_b;
    logic              r_cin;
    logic [GROUPS-1:0] r_rcon;
    logic              r_s1_valid;
    logic [SIZE-1:0]   r_sum;
    logic              r_cout;
    logic              r_approx;
    logic              r_out_valid;
    logic [7:0]        r_phase;
    logic [CNTW-1:0]   r_ops;
    logic [CNTW-1:0]   r_apx;

    logic              w_s2_free;
    logic              w_xfer;
    logic              w_acc;
    logic              w_ret;
    logic              w_per_ok;
    logic [7:0]        w_last;
    logic [7:0]        w_phase_nxt;
    logic [GROUPS-1:0] w_rcon;

    assign w_s2_free = !r_out_valid || out_ready;
    assign w_xfer    = r_s1_valid && w_s2_free;
    assign in_ready  = rst_n && (!r_s1_valid || w_s2_free);
    assign w_acc     = in_valid && in_ready;
    assign w_ret     = r_out_valid && out_ready;

    // Periodic mode: one exact beat at the end of each period.
    assign w_per_ok    = cfg_period >= 8'd2;
    assign w_last      = cfg_period - 8'd1;
    assign w_phase_nxt = (!w_per_ok || r_phase >= w_last) ? 8'd0
                                                          : r_phase + 8'd1;

    always_comb begin
        w_rcon = '0;
        unique case (cfg_mode)
            MODE_EXACT:  w_rcon = '0;
            MODE_APPROX: w_rcon = '1;
            MODE_MASK:   w_rcon = cfg_mask;
            MODE_PERIOD: w_rcon = (w_per_ok && r_phase != w_last) ? '1 : '0;
            default:     w_rcon = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_rcon      <= '0;
            r_s1_valid  <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_approx    <= 1'b0;
            r_out_valid <= 1'b0;
            r_phase     <= 8'd0;
            r_ops       <= '0;
            r_apx       <= '0;
        end else begin
            if (w_acc) begin
                r_a        <= in_a;
                r_b        <= in_b;
                r_cin      <= in_cin;
                r_rcon     <= w_rcon;
                r_s1_valid <= 1'b1;
            end else if (w_xfer) begin
                r_s1_valid <= 1'b0;
            end

            if (w_xfer) begin
                r_sum       <= add_sum;
                r_cout      <= add_cout;
                r_approx    <= |r_rcon;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (cfg_mode != MODE_PERIOD) begin
                r_phase <= 8'd0;
            end else if (w_acc) begin
                r_phase <= w_phase_nxt;
            end

            // Clear beats a coincident retirement.
            if (stat_clr) begin
                r_ops <= '0;
                r_apx <= '0;
            end else if (w_ret) begin
                if (r_ops != '1) r_ops <= r_ops + CNTW'(1);
                if (r_approx && r_apx != '1) r_apx <= r_apx + CNTW'(1);
            end
        end
    end

    assign add_a       = r_a;
    assign add_b       = r_b;
    assign add_cin     = r_cin;
    assign add_rcon    = r_rcon;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_sum;
    assign out_cout    = r_cout;
    assign out_approx  = r_approx;
    assign stat_ops    = r_ops;
    assign stat_approx = r_apx;
endmodule

// File: tb/tb_rapcla_issue_stage.sv
// Bench for rapcla_issue_stage: queue-based model, stub adder, directed beats.
// A second instance with 4-bit counters exercises saturation.
module tb_rapcla_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [3:0]  cfg_mask = '0;
    logic [7:0]  cfg_period = 8'd0;
    logic        out_ready = 1'b1;
    logic        stat_clr = 1'b0;

    logic        in_ready, add_cin, add_cout, out_valid, out_cout, out_approx;
    logic [15:0] add_a, add_b, add_sum, out_sum, stat_ops, stat_approx;
    logic [3:0]  add_rcon;

    logic        s_in_ready, s_add_cin, s_add_cout, s_out_valid;
    logic        s_out_cout, s_out_approx;
    logic [15:0] s_add_a, s_add_b, s_add_sum, s_out_sum;
    logic [3:0]  s_add_rcon, s_stat_ops, s_stat_approx;

    always #5 clk = ~clk;

    // Stub adder: a group with its rcon bit set ignores the incoming carry.
    function automatic logic [16:0] rapcla(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic [3:0] rcon);
        logic c;
        logic [4:0] t;
        logic [15:0] s;
        c = cin;
        s = '0;
        for (int g = 0; g < 4; g++) begin
            if (g > 0 && rcon[g]) c = 1'b0;
            t = {1'b0, a[g*4+:4]} + {1'b0, b[g*4+:4]} + {4'b0, c};
            s[g*4+:4] = t[3:0];
            c = t[4];
        end
        return {c, s};
    endfunction

    assign {add_cout, add_sum}     = rapcla(add_a, add_b, add_cin, add_rcon);
    assign {s_add_cout, s_add_sum} = rapcla(s_add_a, s_add_b, s_add_cin, s_add_rcon);

    rapcla_issue_stage #(.SIZE(16), .GROUPSIZE(4), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .cfg_mode(cfg_mode),
        .cfg_mask(cfg_mask), .cfg_period(cfg_period), .add_a(add_a),
        .add_b(add_b), .add_cin(add_cin), .add_rcon(add_rcon),
        .add_sum(add_sum), .add_cout(add_cout), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
        .out_approx(out_approx), .stat_clr(stat_clr), .stat_ops(stat_ops),
        .stat_approx(stat_approx)
    );

    rapcla_issue_stage #(.SIZE(16), .GROUPSIZE(4), .CNTW(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .cfg_mode(cfg_mode),
        .cfg_mask(cfg_mask), .cfg_period(cfg_period), .add_a(s_add_a),
        .add_b(s_add_b), .add_cin(s_add_cin), .add_rcon(s_add_rcon),
        .add_sum(s_add_sum), .add_cout(s_add_cout), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_sum(s_out_sum), .out_cout(s_out_cout),
        .out_approx(s_out_approx), .stat_clr(stat_clr), .stat_ops(s_stat_ops),
        .stat_approx(s_stat_approx)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: in-flight beats in order; age>0 at the head means it sits in S2.
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [3:0]  rcon;
        int          age;
    } beat_t;

    beat_t q[$];
    int    m_phase = 0;
    int    m_ops = 0;
    int    m_apx = 0;
    logic  m_acc = 1'b0;
    logic  chk_en = 1'b0;

    function automatic logic [3:0] policy(input logic [1:0] mode, input logic [3:0] mask,
                                          input int period, input int phase);
        case (mode)
            2'd0:    return 4'b0000;
            2'd1:    return 4'b1111;
            2'd2:    return mask;
            default: return (period >= 2 && phase != period - 1) ? 4'b1111 : 4'b0000;
        endcase
    endfunction

    always @(posedge clk) begin
        logic  ov, rdy, ret, acc;
        beat_t nb;
        ov  = q.size() > 0 && q[0].age > 0;
        rdy = rst_n && (q.size() < 2 || out_ready);
        ret = ov && out_ready;
        acc = in_valid && rdy;
        m_acc = acc;
        if (!rst_n) begin
            q.delete();
            m_phase = 0;
            m_ops = 0;
            m_apx = 0;
        end else begin
            if (stat_clr) begin
                m_ops = 0;
                m_apx = 0;
            end else if (ret) begin
                m_ops++;
                if (q[0].rcon != 0) m_apx++;
            end
            if (ret) void'(q.pop_front());
            foreach (q[i]) q[i].age = q[i].age + 1;
            if (acc) begin
                nb.a = in_a;
                nb.b = in_b;
                nb.cin = in_cin;
                nb.rcon = policy(cfg_mode, cfg_mask, int'(cfg_period), m_phase);
                nb.age = 0;
                q.push_back(nb);
            end
            if (cfg_mode != 2'd3) m_phase = 0;
            else if (acc) m_phase = (m_phase + 1 >= int'(cfg_period)) ? 0 : m_phase + 1;
        end
    end

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(negedge clk) begin
        logic        ov;
        logic [16:0] r;
        int          s1;
        if (chk_en) begin
            ov = q.size() > 0 && q[0].age > 0;
            check("out_valid", out_valid, ov);
            check("in_ready", in_ready, rst_n && (q.size() < 2 || out_ready));
            if (ov) begin
                r = rapcla(q[0].a, q[0].b, q[0].cin, q[0].rcon);
                check("out_sum", out_sum, r[15:0]);
                check("out_cout", out_cout, r[16]);
                check("out_approx", out_approx, q[0].rcon != 0);
            end
            s1 = ov ? 1 : 0;
            if (q.size() > s1) begin
                check("add_a", add_a, q[s1].a);
                check("add_b", add_b, q[s1].b);
                check("add_cin", add_cin, q[s1].cin);
                check("add_rcon", add_rcon, q[s1].rcon);
            end
            check("stat_ops", stat_ops, sat(m_ops, 65535));
            check("stat_approx", stat_approx, sat(m_apx, 65535));
            check("sat_ops", s_stat_ops, sat(m_ops, 15));
            check("sat_approx", s_stat_approx, sat(m_apx, 15));
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
        int n;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_acc && n < 50);
        if (!m_acc) check("accept_timeout", 0, 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        stat_clr = 1'b1;
        @(negedge clk);
        #1 stat_clr = 1'b0;
    endtask

    logic [3:0] per_exp [8] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_stat_ops", stat_ops, 0);
        check("rst_add_a", add_a, 0);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // exact single beat
        cfg_mode = 2'd0;
        send(16'h00FF, 16'h0001, 1'b0);
        check("t1_rcon", add_rcon, 4'b0000);
        @(negedge clk);
        check("t1_sum", out_sum, 16'h0100);
        check("t1_cout", out_cout, 0);
        check("t1_approx", out_approx, 0);
        idle(2);
        clr_pulse();

        // all-approx streaming
        cfg_mode = 2'd1;
        repeat (4) send(16'hFFFF, 16'h0001, 1'b0);
        check("t2_sum", out_sum, 16'hFFF0);
        check("t2_approx", out_approx, 1);
        idle(3);
        check("t2_ops", stat_ops, 4);
        check("t2_apx", stat_approx, 4);
        clr_pulse();

        // periodic exact
        cfg_mode = 2'd3;
        cfg_period = 8'd4;
        for (int i = 0; i < 8; i++) begin
            send(16'(i * 16'h0111), 16'h0F0F, 1'b1);
            check("t3_rcon", add_rcon, per_exp[i]);
        end
        idle(3);
        check("t3_ops", stat_ops, 8);
        check("t3_apx", stat_approx, 6);
        clr_pulse();

        // backpressure
        cfg_mode = 2'd0;
        out_ready = 1'b0;
        send(16'h1111, 16'h0001, 1'b0);
        send(16'h2222, 16'h0002, 1'b0);
        in_a = 16'h3333;
        in_b = 16'h0003;
        in_valid = 1'b1;
        @(negedge clk);
        check("t4_full", in_ready, 0);
        check("t4_sum_head", out_sum, 16'h1112);
        #1 out_ready = 1'b1;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!m_acc && n < 50);
            if (!m_acc) check("t4_accept_timeout", 0, 1);
        end
        check("t4_sum_second", out_sum, 16'h2224);
        #1 in_valid = 1'b0;
        idle(3);
        check("t4_ops", stat_ops, 3);

        // mask mode, mask changed while beat in S1
        cfg_mode = 2'd2;
        cfg_mask = 4'b0101;
        send(16'h0F0F, 16'h0101, 1'b0);
        check("t5_rcon", add_rcon, 4'b0101);
        cfg_mask = 4'b0000;
        @(negedge clk);
        check("t5_approx", out_approx, 1);
        idle(2);

        // saturation on the 4-bit instance
        clr_pulse();
        cfg_mode = 2'd0;
        for (int i = 0; i < 17; i++) send(16'(i), 16'(i), 1'b0);
        idle(3);
        check("t6_sat", s_stat_ops, 15);
        check("t6_ops", stat_ops, 17);

        // clear coincident with retirement
        clr_pulse();
        cfg_mode = 2'd1;
        send(16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        #1 stat_clr = 1'b1;
        @(negedge clk);
        #1 stat_clr = 1'b0;
        check("t7_ops", stat_ops, 0);
        check("t7_apx", stat_approx, 0);

        // reset mid-stream
        repeat (3) send(16'hA5A5, 16'h5A5A, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t8_valid", out_valid, 0);
        check("t8_ops", stat_ops, 0);
        check("t8_add_a", add_a, 0);
        #1 rst_n = 1'b1;
        idle(3);
        check("t8_quiet", out_valid, 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rapcla_issue_stage.md
# rapcla_issue_stage

Pipelined issue/retire stage wrapped around one combinational RAPCLA adder instance. Accepts operand beats over a valid/ready handshake, registers them, and decides the per-group approximation control `ApproxRCON` from a run-time accuracy policy. The operands and control drive the adder. The block then captures the adder's `SUM`/`COUT` into an output register with its own valid/ready handshake, and keeps exact/approximate operation statistics.

## Interface
- `SIZE`, 16, operand width; must be a multiple of `GROUPSIZE`
- `GROUPSIZE`, 4, adder group size; `GROUPS = SIZE/GROUPSIZE`
- `CNTW`, 16, statistics counter width
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_a`, `in_b`  in  `SIZE`  operands, bit 0 = LSB
- `in_cin`  in  1  carry-in
- `cfg_mode`  in  2  policy: 0 exact, 1 all-approx, 2 mask, 3 periodic
- `cfg_mask`  in  `GROUPS`  per-group approx enable for mode 2, bit 0 = lowest group
- `cfg_period`  in  8  periodic-exact interval for mode 3
- `add_a`, `add_b`  out  `SIZE`  to adder `A`/`B`; `in_a[i]` maps to adder bit i+1
- `add_cin`  out  1  to adder `CIN`
- `add_rcon`  out  `GROUPS`  to adder `ApproxRCON`; bit 0 maps to group 1
- `add_sum`  in  `SIZE`  from adder `SUM`, same bit mapping
- `add_cout`  in  1  from adder `COUT`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_sum`  out  `SIZE`  registered sum
- `out_cout`  out  1  registered carry-out
- `out_approx`  out  1  result was produced with any `add_rcon` bit set
- `stat_clr`  in  1  synchronous clear of statistics
- `stat_ops`  out  `CNTW`  retired results
- `stat_approx`  out  `CNTW`  retired approximate results

## Operation
- **S1 (operand register).**
  - Holds `add_a`, `add_b`, `add_cin`, `add_rcon`, and `s1_valid`.
  - The adder is combinational between S1 and S2.
- **S2 (result register).**
  - Holds `out_sum`, `out_cout`, `out_approx`, and `out_valid`.
- **Advance rules.**
  - `s2_free = !out_valid || out_ready`.
  - S1→S2 transfer when `s1_valid && s2_free`.
  - `in_ready = !s1_valid || s2_free`. It is combinational and forced to 0 while `rst_n` is low.
  - Input is accepted on `in_valid && in_ready`. S1 loads the operands, and `add_rcon` is computed from the policy at that moment.
  - If S1 transfers with no new input, `s1_valid` clears.
  - If S2 empties with no transfer, `out_valid` clears.
- **Policy, evaluated at acceptance.**
  - Mode 0: `add_rcon` = all 0.
  - Mode 1: `add_rcon` = all 1.
  - Mode 2: `add_rcon` = `cfg_mask`.
  - Mode 3 with `cfg_period` ≥ 2: `add_rcon` = all 0 when `phase == cfg_period-1`, otherwise all 1.
  - Mode 3 with `cfg_period` of 0 or 1: `add_rcon` = all 0.
- **Phase counter (8 bits).**
  - Increments on each accepted beat in mode 3 and wraps to 0 after `cfg_period-1`.
  - Forced to 0 whenever `cfg_mode != 3`.
  - If `cfg_period` drops to or below `phase`, the next accepted beat wraps phase to 0.
- `out_approx` is captured as `|add_rcon` at the S1→S2 transfer.
- **Statistics.**
  - On `out_valid && out_ready`, `stat_ops` increments, and `stat_approx` increments if `out_approx`.
  - Both counters saturate at all-ones.
  - `stat_clr` zeroes both and wins over a same-cycle increment.
- **Reset.**
  - All registers clear: `out_*`, `add_*`, `s1_valid`, phase, and statistics go to 0.
  - Reset asserted mid-operation discards in-flight beats with no output handshake.
- Configuration inputs may change on any cycle. Beats already in S1/S2 keep the control they were issued with.

## Timing
- Beat accepted at edge t: `add_*` are valid after edge t, and the result is registered at edge t+1. `out_valid` is high from edge t+1.
- Throughput is one beat per cycle when `out_ready` stays high.
- Capacity is 2 beats. With `out_ready` low, `in_ready` drops once S1 and S2 are both full. No beat is lost or duplicated.
- When `out_ready` returns high with both stages full, in the same cycle: S2 retires, S1 moves to S2, and S1 may accept a new beat.
- The adder's combinational path must settle within one `clk` period.

## Test plan
- Reset, then mode 0, `in_a`=0x00FF, `in_b`=0x0001, `in_cin`=0 → `add_rcon`=0000, `out_sum`=0x0100, `out_cout`=0, `out_approx`=0 one cycle after acceptance.
- Mode 1, operands 0xFFFF+0x0001 streamed 4 beats back-to-back with `out_ready`=1 → 4 results on consecutive cycles, each `out_approx`=1. Then `stat_ops`=4 and `stat_approx`=4.
- Mode 3 with `cfg_period`=4, 8 beats → `add_rcon`=1111,1111,1111,0000,1111,1111,1111,0000. Then `stat_approx`=6.
- Backpressure: `out_ready`=0 while offering 3 beats → `in_ready` low after 2 acceptances. Raising `out_ready` → results retire in order, with no loss or duplication.
- Mode 2 with `cfg_mask`=0101 → `add_rcon`=0101. Changing the mask while a beat is in S1 does not alter that beat's `out_approx`.
- Counter edge cases:
  - Preload to saturation with `CNTW`=4 and 17 retirements → `stat_ops`=15.
  - `stat_clr` coincident with a retirement → both counters read 0.
  - `rst_n` low mid-stream → `out_valid`=0 and counters 0 on the next edge.
